// File: rtl/arbiter_n_to_1_rr_request.sv
// Round-robin N-to-1 request arbiter with bounded bursts and a registered output stage.
// A grant holds for up to MAX_BURST accepted beats or until the owner drops its request.
module arbiter_n_to_1_rr_request #(
  parameter int unsigned NUM_MEMORY_REQUESTOR = 4,
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned MAX_BURST            = 4
) (
  input  logic                                       ap_clk,
  input  logic                                       areset,
  input  logic [NUM_MEMORY_REQUESTOR-1:0]            req_valid,
  input  logic [NUM_MEMORY_REQUESTOR*DATA_WIDTH-1:0] req_payload,
  output logic [NUM_MEMORY_REQUESTOR-1:0]            req_ready,
  output logic                                       out_valid,
  output logic [DATA_WIDTH-1:0]                      out_payload,
  output logic [NUM_MEMORY_REQUESTOR-1:0]            out_grant_id,
  input  logic                                       out_ready,
  output logic                                       busy
);

  localparam int unsigned N     = NUM_MEMORY_REQUESTOR;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [7:0]  LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [N-1:0]            grant_q, grant_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_payload_q, out_payload_d;
  logic [N-1:0]            out_grant_id_q, out_grant_id_d;

  logic                    out_free;
  logic                    accept;
  logic                    owner_valid;
  logic [IDX_W-1:0]        g_idx;
  logic [IDX_W-1:0]        next_ptr;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;

  assign out_free    = !out_valid_q || out_ready;
  assign req_ready   = (state_q == GRANT && out_free) ? grant_q : '0;
  assign accept      = |(req_valid & req_ready);
  assign owner_valid = |(req_valid & grant_q);
  assign next_ptr    = (g_idx == IDX_W'(N - 1)) ? '0 : g_idx + IDX_W'(1);

  assign out_valid    = out_valid_q;
  assign out_payload  = out_payload_q;
  assign out_grant_id = out_grant_id_q;
  assign busy         = (state_q == GRANT) || out_valid_q;

  // Index of the current one-hot grant.
  always_comb begin
    g_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant_q[k]) g_idx = IDX_W'(k);
    end
  end

  // First valid requester at or above rr_ptr, wrapping at N.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!pick_found && req_valid[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    beat_cnt_d     = beat_cnt_q;
    out_valid_d    = out_valid_q;
    out_payload_d  = out_payload_q;
    out_grant_id_d = out_grant_id_q;

    if (accept) begin
      out_valid_d    = 1'b1;
      out_payload_d  = req_payload[32'(g_idx) * DATA_WIDTH +: DATA_WIDTH];
      out_grant_id_d = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d    = GRANT;
        grant_d    = N'(1) << pick_idx;
        beat_cnt_d = '0;
      end
    end else begin
      // Release on owner drop or on the last beat of the burst; a stall holds everything.
      if (!owner_valid || (accept && beat_cnt_q == LAST_BEAT)) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
        grant_d  = '0;
      end
      if (accept) beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      beat_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      out_grant_id_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      beat_cnt_q     <= beat_cnt_d;
      out_valid_q    <= out_valid_d;
      out_payload_q  <= out_payload_d;
      out_grant_id_q <= out_grant_id_d;
    end
  end

endmodule

// File: tb/tb_arbiter_n_to_1_rr_request.sv
// Scoreboard bench for arbiter_n_to_1_rr_request: N=4, 16-bit payload, bursts of 2.
// Payload of requester i in bench cycle c is {i[3:0], c[11:0]}, so every beat is traceable.
module tb_arbiter_n_to_1_rr_request;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 2;

  logic            ap_clk;
  logic            areset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_payload;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_payload;
  logic [N-1:0]    out_grant_id;
  logic            out_ready;
  logic            busy;

  arbiter_n_to_1_rr_request #(
    .NUM_MEMORY_REQUESTOR(N),
    .DATA_WIDTH(DW),
    .MAX_BURST(MB)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .req_valid(req_valid),
    .req_payload(req_payload),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_payload(out_payload),
    .out_grant_id(out_grant_id),
    .out_ready(out_ready),
    .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_pushed = 0;
  int beats_seen = 0;
  logic [N+DW-1:0] exp_q[$];
  logic [N+DW-1:0] exp_word;

  function automatic logic [DW-1:0] mk(input int id, input int c);
    return {4'(id), 12'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, exp);
  endtask

  task automatic push_beat(input int id, input int c);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    exp_q.push_back({oh, mk(id, c)});
    n_pushed++;
  endtask

  task automatic drive_payload();
    for (int i = 0; i < int'(N); i++) req_payload[i*DW +: DW] = mk(i, cyc);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
    cyc++;
    drive_payload();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic at_neg();
    @(negedge ap_clk);
  endtask

  // Monitor: every beat handed downstream must match the oldest expected beat.
  always @(negedge ap_clk) begin
    if (!areset && out_valid && out_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat (cycle %0d): got id=%b payload=%h, required no beat", cyc, out_grant_id, out_payload);
      end else begin
        exp_word = exp_q.pop_front();
        chk("beat {id,payload}", {out_grant_id, out_payload}, exp_word);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v, t, u, w, x, y, z;
    areset    = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    drive_payload();

    // Reset state
    tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset out_payload", out_payload, 0);
    chk("reset out_grant_id", out_grant_id, 0);

    // Fairness: all requesters valid from the cycle reset drops
    tick();
    areset    = 1'b0;
    req_valid = 4'b1111;
    v = cyc;
    for (int k = 0; k < 5; k++) begin
      push_beat(k % 4, v + 1 + 3 * k);
      push_beat(k % 4, v + 2 + 3 * k);
    end
    at_neg();
    chk("fair idle req_ready", req_ready, 0);
    run_to(v + 1); at_neg();
    chk("fair first grant", req_ready, 4'b0001);
    run_to(v + 3); at_neg();
    chk("fair gap req_ready", req_ready, 0);
    chk("fair gap busy", busy, 1);
    run_to(v + 4); at_neg();
    chk("fair second grant", req_ready, 4'b0010);
    run_to(v + 15);
    req_valid = '0;

    // Single requester 2 with rr_ptr=1: two bursts with one idle cycle between
    run_to(v + 17);
    t = cyc;
    req_valid = 4'b0100;
    push_beat(2, t + 1); push_beat(2, t + 2);
    push_beat(2, t + 4); push_beat(2, t + 5);
    at_neg();
    chk("single idle req_ready", req_ready, 0);
    run_to(t + 1); at_neg();
    chk("single grant", req_ready, 4'b0100);
    run_to(t + 3); at_neg();
    chk("single gap req_ready", req_ready, 0);
    run_to(t + 4); at_neg();
    chk("single regrant", req_ready, 4'b0100);
    run_to(t + 6);
    req_valid = '0;

    // Wrap: rr_ptr=3, requesters 3 and 0 valid
    tick();
    u = cyc;
    req_valid = 4'b1001;
    push_beat(3, u + 1); push_beat(3, u + 2);
    push_beat(0, u + 4); push_beat(0, u + 5);
    run_to(u + 1); at_neg();
    chk("wrap grant 3", req_ready, 4'b1000);
    run_to(u + 4); at_neg();
    chk("wrap grant 0", req_ready, 4'b0001);
    run_to(u + 6);
    req_valid = '0;

    // Early release: requester 1 drops after one beat, requester 2 follows
    tick();
    w = cyc;
    req_valid = 4'b0110;
    push_beat(1, w + 1);
    push_beat(2, w + 4); push_beat(2, w + 5);
    run_to(w + 1); at_neg();
    chk("early grant 1", req_ready, 4'b0010);
    run_to(w + 2);
    req_valid = 4'b0100;
    run_to(w + 3); at_neg();
    chk("early idle req_ready", req_ready, 0);
    chk("early idle busy", busy, 0);
    run_to(w + 4); at_neg();
    chk("early grant 2", req_ready, 4'b0100);
    run_to(w + 6);
    req_valid = '0;

    // Backpressure: five stalled cycles mid-burst
    tick();
    x = cyc;
    req_valid = 4'b0001;
    push_beat(0, x + 1); push_beat(0, x + 7);
    run_to(x + 2);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      at_neg();
      chk("stall req_ready", req_ready, 0);
      chk("stall out_valid", out_valid, 1);
      chk("stall out_payload", out_payload, mk(0, x + 1));
      tick();
    end
    out_ready = 1'b1;
    at_neg();
    chk("stall resume req_ready", req_ready, 4'b0001);
    run_to(x + 8);
    req_valid = '0;

    // Async reset during a stalled burst; held beat is discarded
    tick();
    y = cyc;
    req_valid = 4'b1001;
    run_to(y + 1); at_neg();
    chk("pre-reset grant 3", req_ready, 4'b1000);
    run_to(y + 2);
    out_ready = 1'b0;
    run_to(y + 3);
    #2;
    areset = 1'b1;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async busy", busy, 0);
    chk("async req_ready", req_ready, 0);
    chk("async out_grant_id", out_grant_id, 0);
    tick();
    areset    = 1'b0;
    out_ready = 1'b1;
    z = cyc;
    push_beat(0, z + 1); push_beat(0, z + 2);
    run_to(z + 1); at_neg();
    chk("post-reset grant 0", req_ready, 4'b0001);
    run_to(z + 3);
    req_valid = '0;

    run_to(z + 6); at_neg();
    chk("scoreboard drained", exp_q.size(), 0);
    chk("beat count", beats_seen, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
